// File: rtl/ff_bank_pkg.sv
// ============================================================================
// Package     : ff_bank_pkg
// Description : Shared definitions for the flip-flop bank arbiter: FSM
//               state encoding, default sizing constants and the
//               rotating-index helper used by the priority picker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ff_bank_pkg;

  // Default sizing; the arbiter and picker parameters take these values
  // unless overridden at instantiation.
  localparam int c_NUM_REQ_DEFAULT     = 4;
  localparam int c_WIDTH_DEFAULT       = 8;
  localparam int c_HOLD_CYCLES_DEFAULT = 2;

  // Arbiter FSM state encoding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Returns (base + off) modulo n, assuming base < n and off < n.
  // A single conditional subtract avoids a general modulo operator.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int v_sum;
    v_sum = base + off;
    return (v_sum >= n) ? (v_sum - n) : v_sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational rotating-priority selector. Finds the first
//               asserted request starting at the round-robin pointer and
//               moving upwards, wrapping from NUM_REQ-1 to 0.
// Ports       : i_req     - per-requester request vector
//               i_rr_ptr  - index holding highest priority this transaction
//               o_sel     - index of the selected requester (0 if none)
//               o_any_req - at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
  import ff_bank_pkg::*;
#(
  parameter int NUM_REQ = c_NUM_REQ_DEFAULT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_sel,
  output logic               o_any_req
);

  logic [IDX_W-1:0] w_sel;
  logic             w_found;

  // Walk the offsets in priority order; the first hit latches w_found so
  // later (lower-priority) hits are ignored.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[wrap_idx(int'(i_rr_ptr), k, NUM_REQ)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(wrap_idx(int'(i_rr_ptr), k, NUM_REQ));
      end
    end
  end

  assign o_sel     = w_sel;
  assign o_any_req = |i_req;

endmodule

`default_nettype wire

// File: rtl/ff_bank_arbiter.sv
// ============================================================================
// Module      : ff_bank_arbiter
// Description : Round-robin write controller for one shared WIDTH-bit
//               flip-flop bank. One requester is granted per transaction;
//               its data is loaded into the bank and acknowledged with a
//               single-cycle one-hot grant. After each write the bank can be
//               held stable for HOLD_CYCLES cycles before the next grant.
// Ports       : clk       - rising-edge clock
//               reset     - synchronous reset, active low
//               i_req     - level requests, held until granted
//               i_wdata   - packed write data, requester i at [i*WIDTH +: WIDTH]
//               o_gnt     - registered one-hot grant/ack pulse
//               o_q       - shared register contents
//               o_q_owner - index of the requester that last wrote o_q
//               o_q_valid - o_q has been written since reset
//               o_busy    - hold window active, no grant possible
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_bank_arbiter
  import ff_bank_pkg::*;
#(
  parameter int NUM_REQ     = c_NUM_REQ_DEFAULT,
  parameter int WIDTH       = c_WIDTH_DEFAULT,
  parameter int HOLD_CYCLES = c_HOLD_CYCLES_DEFAULT,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]         o_q,
  output logic [IDX_W-1:0]         o_q_owner,
  output logic                     o_q_valid,
  output logic                     o_busy
);

  // Counter preload for the hold window. With HOLD_CYCLES=0 the HOLD state
  // is never entered, so the value is irrelevant and clamped to zero.
  localparam logic [3:0]         c_HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
  localparam logic [IDX_W-1:0]   c_LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_GNT_ONE   = NUM_REQ'(1);

  state_t               r_state;
  logic [3:0]           r_hold_cnt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [WIDTH-1:0]     r_q;        // the shared d_ff bank
  logic [IDX_W-1:0]     r_q_owner;
  logic                 r_q_valid;
  logic                 r_busy;

  logic [IDX_W-1:0]     w_sel;
  logic                 w_any_req;
  logic [IDX_W-1:0]     w_ptr_next;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req     (i_req),
    .i_rr_ptr  (r_rr_ptr),
    .o_sel     (w_sel),
    .o_any_req (w_any_req)
  );

  // The winner gets lowest priority next time; explicit wrap keeps this
  // correct when NUM_REQ is not a power of two.
  assign w_ptr_next = (w_sel == c_LAST_IDX) ? '0 : (w_sel + 1'b1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_q        <= '0;
      r_q_owner  <= '0;
      r_q_valid  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Grant is a single-cycle pulse unless re-asserted below.
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_q       <= i_wdata[int'(w_sel)*WIDTH +: WIDTH];
            r_gnt     <= c_GNT_ONE << w_sel;
            r_q_owner <= w_sel;
            r_q_valid <= 1'b1;
            r_rr_ptr  <= w_ptr_next;
            // busy rises together with the grant so it covers exactly
            // HOLD_CYCLES cycles starting at the grant cycle.
            if (HOLD_CYCLES > 0) begin
              r_state    <= ST_HOLD;
              r_hold_cnt <= c_HOLD_LOAD;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_q       = r_q;
  assign o_q_owner = r_q_owner;
  assign o_q_valid = r_q_valid;
  assign o_busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ff_bank_arbiter.sv
// ============================================================================
// Module      : tb_ff_bank_arbiter
// Description : Bench for ff_bank_arbiter. Two instances share the clock:
//               index 0 uses HOLD_CYCLES=2, index 1 uses HOLD_CYCLES=0.
//               A timing-level model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_bank_arbiter;

  localparam int c_N     = 4;
  localparam int c_W     = 8;
  localparam int c_HOLD0 = 2;
  localparam int c_HOLD1 = 0;

  logic clk;
  logic rst_n;
  logic chk_en;

  logic [c_N-1:0]     req [2];
  logic [c_N*c_W-1:0] wd  [2];
  logic [c_N-1:0]     gnt [2];
  logic [c_W-1:0]     q   [2];
  logic [1:0]         own [2];
  logic               vld [2];
  logic               bsy [2];

  // Model state: what the outputs must be after the latest edge.
  logic [c_N-1:0] m_gnt   [2];
  logic [c_W-1:0] m_q     [2];
  logic [1:0]     m_own   [2];
  logic           m_vld   [2];
  logic           m_bsy   [2];
  int             m_ptr   [2];
  int             m_lastg [2];
  int             edge_no;

  int n_checks;
  int n_err;

  ff_bank_arbiter #(.NUM_REQ(c_N), .WIDTH(c_W), .HOLD_CYCLES(c_HOLD0)) dut_a (
    .clk(clk), .reset(rst_n), .i_req(req[0]), .i_wdata(wd[0]),
    .o_gnt(gnt[0]), .o_q(q[0]), .o_q_owner(own[0]), .o_q_valid(vld[0]), .o_busy(bsy[0])
  );

  ff_bank_arbiter #(.NUM_REQ(c_N), .WIDTH(c_W), .HOLD_CYCLES(c_HOLD1)) dut_b (
    .clk(clk), .reset(rst_n), .i_req(req[1]), .i_wdata(wd[1]),
    .o_gnt(gnt[1]), .o_q(q[1]), .o_q_owner(own[1]), .o_q_valid(vld[1]), .o_busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hold_of(input int k);
    return (k == 0) ? c_HOLD0 : c_HOLD1;
  endfunction

  // Model: a grant may occur at edge e only if more than HOLD edges have
  // passed since the last grant edge; busy is high while fewer than HOLD
  // edges have passed. Selection scans upward from the pointer with wrap.
  initial begin
    edge_no = 0;
    forever begin
      @(posedge clk);
      edge_no++;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_gnt[k] = '0; m_q[k] = '0; m_own[k] = '0; m_vld[k] = 1'b0;
          m_bsy[k] = 1'b0; m_ptr[k] = 0; m_lastg[k] = -100;
        end else begin
          int sel;
          sel = -1;
          m_gnt[k] = '0;
          if ((edge_no - m_lastg[k]) > hold_of(k)) begin
            for (int off = 0; off < c_N; off++) begin
              if (sel < 0 && req[k][(m_ptr[k] + off) % c_N]) sel = (m_ptr[k] + off) % c_N;
            end
          end
          if (sel >= 0) begin
            m_gnt[k]   = c_N'(1) << sel;
            m_q[k]     = wd[k][sel*c_W +: c_W];
            m_own[k]   = 2'(sel);
            m_vld[k]   = 1'b1;
            m_ptr[k]   = (sel + 1) % c_N;
            m_lastg[k] = edge_no;
          end
          m_bsy[k] = (edge_no - m_lastg[k]) < hold_of(k);
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("cmp%0d.gnt", k), 32'(gnt[k]), 32'(m_gnt[k]));
          check($sformatf("cmp%0d.q", k),   32'(q[k]),   32'(m_q[k]));
          check($sformatf("cmp%0d.own", k), 32'(own[k]), 32'(m_own[k]));
          check($sformatf("cmp%0d.vld", k), 32'(vld[k]), 32'(m_vld[k]));
          check($sformatf("cmp%0d.bsy", k), 32'(bsy[k]), 32'(m_bsy[k]));
        end
      end
    end
  end

  // Waits (bounded) for any grant on instance 0 and checks its value.
  task automatic wait_gnt_a(input string name, input logic [c_N-1:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[0] == '0 && n < 20);
    check(name, 32'(gnt[0]), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    req[0]   = 4'b1111;
    req[1]   = 4'b1111;
    wd[0]    = {8'hD4, 8'hA5, 8'hB2, 8'hC1};
    wd[1]    = {8'h44, 8'h33, 8'h22, 8'h11};

    // Reset held for two edges with all requests active.
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst.gnt",   32'(gnt[0]), 32'h0);
    check("rst.q",     32'(q[0]),   32'h0);
    check("rst.valid", 32'(vld[0]), 32'h0);
    check("rst.busy",  32'(bsy[0]), 32'h0);
    check("rst.owner", 32'(own[0]), 32'h0);
    check("rst.gnt_b", 32'(gnt[1]), 32'h0);
    rst_n  = 1'b1;
    req[0] = '0;
    req[1] = '0;

    // Single request from requester 2.
    @(negedge clk);
    req[0] = 4'b0100;
    @(negedge clk);
    check("single.gnt",   32'(gnt[0]), 32'h4);
    check("single.q",     32'(q[0]),   32'hA5);
    check("single.owner", 32'(own[0]), 32'h2);
    check("single.valid", 32'(vld[0]), 32'h1);
    check("single.busy0", 32'(bsy[0]), 32'h1);
    req[0] = '0;
    @(negedge clk);
    check("single.busy1", 32'(bsy[0]), 32'h1);
    check("single.gnt1",  32'(gnt[0]), 32'h0);
    @(negedge clk);
    check("single.busy2", 32'(bsy[0]), 32'h0);

    // Request arriving during the hold window waits for it to expire.
    req[0] = 4'b0001;
    @(negedge clk);
    check("hold.gnt0", 32'(gnt[0]), 32'h1);
    check("hold.q0",   32'(q[0]),   32'hC1);
    req[0] = 4'b0010;
    @(negedge clk);
    check("hold.gap1", 32'(gnt[0]), 32'h0);
    check("hold.bsy1", 32'(bsy[0]), 32'h1);
    @(negedge clk);
    check("hold.gap2", 32'(gnt[0]), 32'h0);
    check("hold.bsy2", 32'(bsy[0]), 32'h0);
    @(negedge clk);
    check("hold.gnt1", 32'(gnt[0]), 32'h2);
    check("hold.q1",   32'(q[0]),   32'hB2);
    req[0] = '0;

    // Pointer wrap: grant 3, then 0 beats 3.
    req[0] = 4'b1000;
    wait_gnt_a("wrap.first3", 4'b1000);
    req[0] = 4'b1001;
    wait_gnt_a("wrap.then0", 4'b0001);
    req[0] = 4'b1000;
    wait_gnt_a("wrap.then3", 4'b1000);
    req[0] = '0;

    // Back-to-back round robin on the zero-hold instance.
    @(negedge clk);
    req[1] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] v_wd;
      v_wd = 32'(wd[1]);
      @(negedge clk);
      check($sformatf("rr.gnt%0d", i), 32'(gnt[1]), 32'(1) << (i % 4));
      check($sformatf("rr.q%0d", i),   32'(q[1]),   32'(v_wd[(i % 4)*8 +: 8]));
    end
    req[1] = '0;

    // Reset in the middle of a hold window.
    req[0] = 4'b0100;
    wait_gnt_a("midrst.gnt", 4'b0100);
    check("midrst.busy_pre", 32'(bsy[0]), 32'h1);
    rst_n  = 1'b0;
    req[0] = '0;
    @(negedge clk);
    check("midrst.busy",  32'(bsy[0]), 32'h0);
    check("midrst.q",     32'(q[0]),   32'h0);
    check("midrst.valid", 32'(vld[0]), 32'h0);
    check("midrst.owner", 32'(own[0]), 32'h0);
    rst_n  = 1'b1;
    req[0] = 4'b1010;
    wait_gnt_a("midrst.first", 4'b0010);
    check("midrst.q1",    32'(q[0]),   32'hB2);
    check("midrst.own1",  32'(own[0]), 32'h1);
    req[0] = '0;

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
